// File: rtl/cmp_arbiter.sv
// rtl/cmp_arbiter.sv - round-robin arbitrated front end for a shared unsigned magnitude comparator
//
// Several requesters share one comparator. Each requester offers an operand pair
// on a valid/ready handshake. A round-robin arbiter picks one requester at a time,
// and a three-state FSM (IDLE -> CMP -> RESP) runs the compare. The result comes
// back as registered less/greater/equal flags, tagged with the requester index.
//
// Ports:
//   clk            clock, rising edge
//   rst_n          synchronous active-low reset
//   req_valid      [N_REQ]        per-requester request valid
//   req_ready      [N_REQ]        per-requester accept (one-hot or zero)
//   req_inp1       [N_REQ*WIDTH]  operand 1, requester i at [i*WIDTH +: WIDTH]
//   req_inp2       [N_REQ*WIDTH]  operand 2, same packing
//   rsp_valid      result valid (RESP state)
//   rsp_ready      result consumer accept
//   rsp_id         [ID_W]         requester that owns the result
//   rsp_a_less     inp1 <  inp2
//   rsp_a_greater  inp1 >  inp2
//   rsp_equal      inp1 == inp2
//   busy           FSM not in IDLE
//   txn_count      [16]           completed transactions, wrapping
module cmp_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16,
    parameter int ID_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_inp1,
    input  logic [N_REQ*WIDTH-1:0] req_inp2,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   rsp_a_less,
    output logic                   rsp_a_greater,
    output logic                   rsp_equal,
    output logic                   busy,
    output logic [15:0]            txn_count
);

    localparam int N_SLICE = WIDTH / 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state, next_state;

    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  id_q;
    logic [WIDTH-1:0] inp1_q, inp2_q;

    // ------------------------------------------------------------------
    // Round-robin grant: first valid bit scanning upward from rr_ptr, with wrap
    // ------------------------------------------------------------------
    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W:0]   cand;
    logic [ID_W:0]   ptr_inc;
    logic [ID_W-1:0] ptr_next;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(N_REQ)) begin
                cand = cand - (ID_W+1)'(N_REQ);
            end
            if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_W-1:0];
            end
        end
    end

    // Pointer moves to the requester just after the one granted
    always_comb begin
        ptr_inc = {1'b0, grant_idx} + (ID_W+1)'(1);
        if (ptr_inc >= (ID_W+1)'(N_REQ)) begin
            ptr_next = '0;
        end else begin
            ptr_next = ptr_inc[ID_W-1:0];
        end
    end

    // Operand select for the granted requester
    logic [WIDTH-1:0] sel_inp1, sel_inp2;

    always_comb begin
        sel_inp1 = '0;
        sel_inp2 = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_inp1 = req_inp1[i*WIDTH +: WIDTH];
                sel_inp2 = req_inp2[i*WIDTH +: WIDTH];
            end
        end
    end

    logic accept;
    assign accept = (state == S_IDLE) && grant_found;

    // The granted bit is a set req_valid bit, so ready implies the handshake
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign rsp_valid = (state == S_RESP);
    assign busy      = (state != S_IDLE);

    // ------------------------------------------------------------------
    // Comparator: bit cells -> 4-bit slices -> cascade, MSB slice dominant
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   bit_gt, bit_lt, bit_eq;
    logic [N_SLICE-1:0] sl_gt, sl_lt, sl_eq;
    logic               cmp_gt, cmp_lt, cmp_eq;

    assign bit_gt = inp1_q & ~inp2_q;
    assign bit_lt = ~inp1_q & inp2_q;
    assign bit_eq = ~(inp1_q ^ inp2_q);

    for (genvar s = 0; s < N_SLICE; s++) begin : g_slice
        localparam int B = s * 4;
        assign sl_gt[s] = bit_gt[B+3]
                        | (bit_eq[B+3] & bit_gt[B+2])
                        | (bit_eq[B+3] & bit_eq[B+2] & bit_gt[B+1])
                        | (bit_eq[B+3] & bit_eq[B+2] & bit_eq[B+1] & bit_gt[B]);
        assign sl_lt[s] = bit_lt[B+3]
                        | (bit_eq[B+3] & bit_lt[B+2])
                        | (bit_eq[B+3] & bit_eq[B+2] & bit_lt[B+1])
                        | (bit_eq[B+3] & bit_eq[B+2] & bit_eq[B+1] & bit_lt[B]);
        assign sl_eq[s] = &bit_eq[B+3:B];
    end

    // Walk slices upward; a higher unequal slice overrides every lower one
    always_comb begin
        cmp_gt = 1'b0;
        cmp_lt = 1'b0;
        for (int s = 0; s < N_SLICE; s++) begin
            if (!sl_eq[s]) begin
                cmp_gt = sl_gt[s];
                cmp_lt = sl_lt[s];
            end
        end
    end

    assign cmp_eq = ~cmp_gt & ~cmp_lt;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (grant_found) next_state = S_CMP;
            S_CMP:   next_state = S_RESP;
            S_RESP:  if (rsp_ready) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            rr_ptr        <= '0;
            inp1_q        <= '0;
            inp2_q        <= '0;
            id_q          <= '0;
            rsp_id        <= '0;
            rsp_a_less    <= 1'b0;
            rsp_a_greater <= 1'b0;
            rsp_equal     <= 1'b0;
            txn_count     <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                inp1_q <= sel_inp1;
                inp2_q <= sel_inp2;
                id_q   <= grant_idx;
                rr_ptr <= ptr_next;
            end
            if (state == S_CMP) begin
                rsp_a_less    <= cmp_lt;
                rsp_a_greater <= cmp_gt;
                rsp_equal     <= cmp_eq;
                rsp_id        <= id_q;
            end
            if (state == S_RESP && rsp_ready) begin
                txn_count <= txn_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_cmp_arbiter.sv
// tb/tb_cmp_arbiter.sv - self-checking bench for cmp_arbiter
module tb_cmp_arbiter;

    localparam int N_REQ = 4;
    localparam int WIDTH = 16;
    localparam int ID_W  = 2;

    logic                   clk;
    logic                   rst_n;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_inp1;
    logic [N_REQ*WIDTH-1:0] req_inp2;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic                   rsp_a_less;
    logic                   rsp_a_greater;
    logic                   rsp_equal;
    logic                   busy;
    logic [15:0]            txn_count;

    cmp_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_inp1      (req_inp1),
        .req_inp2      (req_inp2),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_a_less    (rsp_a_less),
        .rsp_a_greater (rsp_a_greater),
        .rsp_equal     (rsp_equal),
        .busy          (busy),
        .txn_count     (txn_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic        lt;
        logic        gt;
        logic        eq;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are read on the falling edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 12 && !done; i++) begin
            sample();
            if (!busy) done = 1'b1;
            else step();
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_idle: busy still 1 after 12 cycles, required 0");
        end
    endtask

    logic [15:0] exp_txn;
    logic [3:0]  rr_ready[$];
    int          rr_cycle[$];
    int          exp_order[8];
    int          seen_rsp;

    initial begin
        vecs[0] = '{0, 16'h1234, 16'h1235, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{2, 16'h8000, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{3, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1, 16'hF000, 16'h0FFF, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{2, 16'h00F1, 16'h00F0, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{0, 16'h7FFF, 16'h8000, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{3, 16'h5A5A, 16'h5A6A, 1'b1, 1'b0, 1'b0};
        exp_order = '{0, 1, 2, 3, 0, 2, 3, 0};

        rst_n     = 1'b0;
        req_valid = '0;
        req_inp1  = '0;
        req_inp2  = '0;
        rsp_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        sample();
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_txn_count", 32'(txn_count), 32'd0);
        check("reset_flags", {29'd0, rsp_a_less, rsp_a_greater, rsp_equal}, 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);

        // Table-driven single-requester transactions
        exp_txn = 16'd0;
        for (int v = 0; v < 9; v++) begin
            step();
            req_valid = 4'b0001 << vecs[v].id;
            req_inp1[vecs[v].id*WIDTH +: WIDTH] = vecs[v].a;
            req_inp2[vecs[v].id*WIDTH +: WIDTH] = vecs[v].b;
            sample();
            check($sformatf("v%0d_req_ready", v), 32'(req_ready), 32'(4'b0001 << vecs[v].id));
            step();
            req_valid = '0;
            sample();
            check($sformatf("v%0d_cmp_busy", v), 32'(busy), 32'd1);
            check($sformatf("v%0d_cmp_rsp_valid", v), 32'(rsp_valid), 32'd0);
            step();
            sample();
            check($sformatf("v%0d_rsp_valid", v), 32'(rsp_valid), 32'd1);
            check($sformatf("v%0d_rsp_id", v), 32'(rsp_id), 32'(vecs[v].id));
            check($sformatf("v%0d_flags", v), {29'd0, rsp_a_less, rsp_a_greater, rsp_equal},
                  {29'd0, vecs[v].lt, vecs[v].gt, vecs[v].eq});
            rsp_ready = 1'b1;
            step();
            exp_txn = exp_txn + 16'd1;
            sample();
            check($sformatf("v%0d_txn_count", v), 32'(txn_count), 32'(exp_txn));
            check($sformatf("v%0d_idle", v), 32'(busy), 32'd0);
            rsp_ready = 1'b0;
        end

        // Round-robin: all valid, then requester 1 drops out at cycle 13
        step();
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 22; cyc++) begin
            if (cyc == 13) req_valid = 4'b1101;
            sample();
            if (req_ready != 4'b0000) begin
                rr_ready.push_back(req_ready);
                rr_cycle.push_back(cyc);
            end
            step();
        end
        req_valid = '0;
        check("rr_grant_count", 32'(rr_ready.size()), 32'd8);
        for (int g = 0; g < 8 && g < rr_ready.size(); g++) begin
            check($sformatf("rr_grant%0d", g), 32'(rr_ready[g]), 32'(4'b0001 << exp_order[g]));
            check($sformatf("rr_cycle%0d", g), 32'(rr_cycle[g]), 32'(3 * g));
        end
        wait_idle();
        exp_txn = exp_txn + 16'd8;
        check("rr_txn_count", 32'(txn_count), 32'(exp_txn));

        // Backpressure: requester 0 in RESP held 5 cycles while requester 3 waits
        rsp_ready = 1'b0;
        step();
        req_valid = 4'b0001;
        req_inp1[0 +: WIDTH] = 16'h0005;
        req_inp2[0 +: WIDTH] = 16'h0003;
        sample();
        check("bp_req_ready0", 32'(req_ready), 32'b0001);
        step();
        req_valid = 4'b1000;
        req_inp1[3*WIDTH +: WIDTH] = 16'h0042;
        req_inp2[3*WIDTH +: WIDTH] = 16'h0042;
        sample();
        check("bp_cmp_req_ready", 32'(req_ready), 32'd0);
        step();
        for (int k = 0; k < 5; k++) begin
            sample();
            check($sformatf("bp%0d_rsp_valid", k), 32'(rsp_valid), 32'd1);
            check($sformatf("bp%0d_flags", k), {29'd0, rsp_a_less, rsp_a_greater, rsp_equal}, 32'b010);
            check($sformatf("bp%0d_rsp_id", k), 32'(rsp_id), 32'd0);
            check($sformatf("bp%0d_req_ready", k), 32'(req_ready), 32'd0);
            check($sformatf("bp%0d_busy", k), 32'(busy), 32'd1);
            step();
        end
        rsp_ready = 1'b1;
        sample();
        check("bp_accept_req_ready", 32'(req_ready), 32'd0);
        step();
        sample();
        check("bp_next_grant3", 32'(req_ready), 32'b1000);
        step();
        req_valid = '0;
        sample();
        step();
        sample();
        check("bp_r3_rsp_id", 32'(rsp_id), 32'd3);
        check("bp_r3_equal", 32'(rsp_equal), 32'd1);
        wait_idle();
        exp_txn = exp_txn + 16'd2;
        check("bp_txn_count", 32'(txn_count), 32'(exp_txn));

        // Reset while in CMP: job dropped, counter and pointer cleared
        step();
        req_valid = 4'b0010;
        req_inp1[1*WIDTH +: WIDTH] = 16'h0001;
        req_inp2[1*WIDTH +: WIDTH] = 16'h0002;
        sample();
        check("rst_req_ready1", 32'(req_ready), 32'b0010);
        step();
        req_valid = '0;
        rst_n = 1'b0;
        sample();
        check("rst_in_cmp", 32'(busy), 32'd1);
        step();
        rst_n = 1'b1;
        seen_rsp = 0;
        for (int k = 0; k < 4; k++) begin
            sample();
            if (rsp_valid) seen_rsp++;
            step();
        end
        check("rst_no_rsp", 32'(seen_rsp), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_txn_count", 32'(txn_count), 32'd0);
        req_valid = 4'b1111;
        sample();
        check("rst_rr_ptr0", 32'(req_ready), 32'b0001);
        req_valid = '0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cmp_arbiter.md
# cmp_arbiter

Sequenced, shared front end for the team's 16-bit unsigned magnitude comparator. Up to `N_REQ` requesters present operand pairs over valid/ready handshakes. A round-robin arbiter grants one requester at a time, and a three-state FSM latches the operands, evaluates the comparator, and returns a registered less/greater/equal result tagged with the requester ID. The block sits between the CPU's issue/branch logic and the comparator datapath so that one comparator serves every client.

## Interface
- `N_REQ`, 4, number of requesters (2..8).
- `WIDTH`, 16, operand width; the comparator tree is built from 4-bit slices, so `WIDTH` must be a multiple of 4.
- `ID_W`, 2, requester ID width; must satisfy `ID_W` = clog2(`N_REQ`).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  `N_REQ`  per-requester request valid.
- `req_ready`  out  `N_REQ`  per-requester accept; one-hot or zero.
- `req_inp1`  in  `N_REQ*WIDTH`  operand 1; requester i uses slice [i*WIDTH +: WIDTH].
- `req_inp2`  in  `N_REQ*WIDTH`  operand 2; same packing as `req_inp1`.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  result consumer accept.
- `rsp_id`  out  `ID_W`  index of the requester that owns the result.
- `rsp_a_less`  out  1  inp1 < inp2 (unsigned).
- `rsp_a_greater`  out  1  inp1 > inp2 (unsigned).
- `rsp_equal`  out  1  inp1 == inp2.
- `busy`  out  1  FSM is not in IDLE.
- `txn_count`  out  16  completed-transaction counter.

## Operation
- **FSM states:** IDLE, CMP, RESP.
- **IDLE, grant:**
  - If any `req_valid` bit is set, grant the first set bit found scanning upward, with wrap, from `rr_ptr`.
  - Assert `req_ready[grant]` combinationally in the same cycle. The handshake completes when valid and ready are both high.
- **IDLE, capture on handshake:**
  - Latch `inp1_q`, `inp2_q` and `id_q` = grant.
  - Set `rr_ptr` = (grant+1) mod `N_REQ`.
  - Go to CMP.
- **IDLE, no requests:** stay in IDLE; `req_ready` = 0.
- **CMP:**
  - The internal comparator evaluates `inp1_q` against `inp2_q` combinationally.
  - Register the three flags into the `rsp_*` registers and go to RESP.
  - `req_ready` = 0.
- **Comparator structure:**
  - 1-bit cells feed 4-bit slices, which feed a cascade across slices, MSB slice dominant.
  - Exactly one of less/greater/equal is 1 for any operand pair.
- **RESP:**
  - `rsp_valid` = 1.
  - `rsp_id`, the flags and the latched operands are held stable.
  - When `rsp_ready` = 1: increment `txn_count` (wraps 0xFFFF to 0x0000) and go to IDLE.
  - `req_ready` stays 0 throughout RESP, including the cycle in which the response is accepted.
- **Fairness:** a requester whose `req_valid` stays high is granted within `N_REQ` transactions.
- **Requester rule:** once `req_valid` is raised, the requester holds it and its operands stable until `req_ready`. The block does not check this.
- **Reset (rst_n = 0 at a rising edge):**
  - FSM goes to IDLE and `rr_ptr` = 0.
  - `inp1_q`, `inp2_q`, `id_q` = 0.
  - `rsp_a_less`, `rsp_a_greater`, `rsp_equal` = 0, `rsp_id` = 0, `txn_count` = 0.
  - An in-flight transaction is dropped with no response issued.
  - Derived outputs after reset: `rsp_valid` = 0, `busy` = 0, `req_ready` = 0.

## Timing
- **Accept:** the handshake happens in cycle T (IDLE).
  - CMP occupies cycle T+1.
  - `rsp_valid` first rises in T+2.
  - Accept-to-response latency is 2 cycles.
- **Throughput:** with `rsp_ready` tied high, the next accept is at T+3. Maximum rate is one transaction per 3 cycles.
- **Backpressure:** each cycle with `rsp_ready` = 0 in RESP adds one cycle. No new request is accepted during that time.
- **Output sources:**
  - `req_ready`, `rsp_valid` and `busy` are decoded from state only. `req_ready` is additionally gated by `req_valid` and the grant.
  - No combinational path exists from `rsp_ready` to `req_ready`.
- **Simultaneous requests in IDLE:** only one is granted; the others see `req_ready` = 0 and wait.

## Test plan
- **Single requester:** reset, then `req_valid` = 0001, inp1 = 0x1234, inp2 = 0x1235. Expect `req_ready` = 0001 the same cycle; two cycles later `rsp_valid` = 1, `rsp_id` = 0, less = 1, greater = 0, equal = 0; `txn_count` = 1 after `rsp_ready`.
- **Compare edges:**
  - Requester 2 sends 0x8000 vs 0x7FFF: expect greater = 1, `rsp_id` = 2.
  - 0xFFFF vs 0xFFFF: expect equal = 1.
  - 0x0000 vs 0x0001: expect less = 1.
  - Every result must be one-hot.
- **Round-robin:**
  - Hold all four valids high with `rsp_ready` = 1: expect grant order 0, 1, 2, 3, 0, with consecutive grants exactly 3 cycles apart.
  - Then drop requester 1's valid: expect the order to skip to 2.
- **Backpressure:** hold `rsp_ready` = 0 for 5 cycles in RESP while requester 3 is valid. Expect the `rsp_*` outputs stable, `req_ready` = 0000, and `busy` = 1; after `rsp_ready` = 1, expect requester 3 granted in the next cycle.
- **Reset mid-operation:** assert `rst_n` = 0 for one cycle while in CMP. Expect IDLE, `rsp_valid` never asserted for the dropped job, `txn_count` = 0, and `rr_ptr` = 0, so requester 0 wins the next contention.
- **Counter wrap:** complete 65536 transactions and expect `txn_count` to return to 0x0000.
